// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// uart_rx_deserializer : oversampled UART receiver with valid/ready output
// Rev 1.0
// ============================================================================
module uart_rx_deserializer #(
   parameter int DATA_BITS = 8,
   parameter int OVS       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int c_tick_w = $clog2(OVS);
   localparam int c_bit_w  = $clog2(DATA_BITS + 1);

   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVS - 1);
   localparam logic [c_tick_w-1:0] c_samp_lo   = c_tick_w'(OVS / 2 - 1);
   localparam logic [c_tick_w-1:0] c_samp_mid  = c_tick_w'(OVS / 2);
   localparam logic [c_tick_w-1:0] c_samp_hi   = c_tick_w'(OVS / 2 + 1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_start     = 3'd1;
   localparam logic [2:0] c_st_data      = 3'd2;
   localparam logic [2:0] c_st_parity    = 3'd3;
   localparam logic [2:0] c_st_stop      = 3'd4;
   localparam logic [2:0] c_st_wait_idle = 3'd5;

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_rxs;
   logic [2:0]           r_state;
   logic [c_tick_w-1:0]  r_tick;
   logic [c_tick_w-1:0]  w_tick_nxt;
   logic [c_bit_w-1:0]   r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_samp0;
   logic                 r_samp1;
   logic                 r_cfg_par_en;
   logic                 r_cfg_odd;
   logic                 r_cfg_two;
   logic                 r_second_stop;
   logic                 r_perr;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 w_in_bit;
   logic                 w_resolve;
   logic                 w_bit;
   logic                 w_par_exp;
   logic                 w_last_stop;
   logic                 w_deliver;
   logic                 w_slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs       = r_sync2;
   assign w_in_bit    = (r_state == c_st_start) || (r_state == c_st_data) ||
                        (r_state == c_st_parity) || (r_state == c_st_stop);
   assign w_tick_nxt  = (r_tick == c_tick_last) ? '0 : r_tick + 1'b1;
   assign w_resolve   = baud_tick && w_in_bit && (w_tick_nxt == c_samp_hi);
   assign w_bit       = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);
   assign w_par_exp   = r_cfg_odd ? ~^r_shift : ^r_shift;
   // A bad first stop bit ends the frame without waiting for the second one.
   assign w_last_stop = !r_cfg_two || r_second_stop || !w_bit;
   // Handoff happens in the final stop-bit resolve cycle, so rx_valid rises on the next edge.
   assign w_deliver   = w_resolve && (r_state == c_st_stop) && w_last_stop;
   assign w_slot_free = !r_rx_valid || rx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= c_st_idle;
         r_tick        <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_samp0       <= 1'b0;
         r_samp1       <= 1'b0;
         r_cfg_par_en  <= 1'b0;
         r_cfg_odd     <= 1'b0;
         r_cfg_two     <= 1'b0;
         r_second_stop <= 1'b0;
         r_perr        <= 1'b0;
      end else begin
         if (baud_tick && w_in_bit) begin
            r_tick <= w_tick_nxt;
            if (w_tick_nxt == c_samp_lo) r_samp0 <= w_rxs;
            if (w_tick_nxt == c_samp_mid) r_samp1 <= w_rxs;
         end
         case (r_state)
            c_st_idle: begin
               if (baud_tick && !w_rxs) begin
                  r_state <= c_st_start;
                  r_tick  <= '0;
               end
            end
            c_st_start: begin
               if (w_resolve) begin
                  if (w_bit) begin
                     r_state <= c_st_idle;
                  end else begin
                     r_state       <= c_st_data;
                     r_bit_cnt     <= '0;
                     r_cfg_par_en  <= parity_en;
                     r_cfg_odd     <= parity_odd;
                     r_cfg_two     <= two_stop;
                     r_second_stop <= 1'b0;
                     r_perr        <= 1'b0;
                  end
               end
            end
            c_st_data: begin
               if (w_resolve) begin
                  r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == c_bit_last) begin
                     r_state <= r_cfg_par_en ? c_st_parity : c_st_stop;
                  end
               end
            end
            c_st_parity: begin
               if (w_resolve) begin
                  r_perr  <= (w_bit != w_par_exp);
                  r_state <= c_st_stop;
               end
            end
            c_st_stop: begin
               if (w_resolve) begin
                  if (w_last_stop) begin
                     r_state <= w_rxs ? c_st_idle : c_st_wait_idle;
                  end else begin
                     r_second_stop <= 1'b1;
                  end
               end
            end
            c_st_wait_idle: begin
               if (baud_tick && w_rxs) r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_deliver) begin
            if (w_slot_free) begin
               r_rx_data    <= r_shift;
               r_parity_err <= r_perr;
               r_frame_err  <= ~w_bit;
               r_rx_valid   <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign parity_err  = r_parity_err;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun;
   assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_deserializer : randomized frame stimulus against a frame-level model
// Rev 1.0
// ============================================================================
module tb_uart_rx_deserializer;

   localparam int DATA_BITS = 8;
   localparam int OVS       = 16;
   localparam int TICK_DIV  = 4;

   typedef struct {
      logic [DATA_BITS-1:0] d;
      logic                 pe;
      logic                 fe;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 baud_tick;
   logic                 rx_in;
   logic                 parity_en;
   logic                 parity_odd;
   logic                 two_stop;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;
   logic                 busy;

   int   checks     = 0;
   int   failures   = 0;
   int   exp_ovr    = 0;
   int   ovr_seen   = 0;
   int   unexpected = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   uart_rx_deserializer #(
      .DATA_BITS(DATA_BITS),
      .OVS      (OVS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick  (baud_tick),
      .rx_in      (rx_in),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .two_stop   (two_stop),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun_err(overrun_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Consumer side: every accepted word is compared with the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun_err) ovr_seen++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               unexpected++;
            end else begin
               mon_e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(mon_e.d));
               check("parity_err", 32'(parity_err), 32'(mon_e.pe));
               check("frame_err", 32'(frame_err), 32'(mon_e.fe));
            end
         end
      end
   end

   // One oversampling period with the line held at v; the DUT sees v on the tick.
   task automatic do_tick(input logic v);
      rx_in = v;
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(rx_valid), 32'd0);
      check({tag, "_data"}, 32'(rx_data), 32'd0);
      check({tag, "_perr"}, 32'(parity_err), 32'd0);
      check({tag, "_ferr"}, 32'(frame_err), 32'd0);
      check({tag, "_ovr"}, 32'(overrun_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [DATA_BITS-1:0] d, input logic pen, input logic podd,
                            input logic tstop, input logic par_ok, input logic stop1,
                            input logic stop2, input bit glitch, input bit drop,
                            input bit chk_lat, input int abort_at);
      logic bits [0:15];
      logic pexp;
      logic v;
      exp_t e;
      int   nb;
      int   fin;
      int   vt;
      int   idx;
      int   gpos;
      pexp    = podd ? ~^d : ^d;
      bits[0] = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = d[i];
      nb = 1 + DATA_BITS;
      if (pen) begin
         bits[nb] = par_ok ? pexp : ~pexp;
         nb++;
      end
      fin      = nb;
      bits[nb] = stop1;
      nb++;
      if (tstop) begin
         bits[nb] = stop2;
         nb++;
         if (stop1) fin = nb - 1;
      end
      e.d  = d;
      e.pe = pen & ~par_ok;
      e.fe = ~stop1 | (tstop & ~stop2);
      if (abort_at < 0) begin
         if (drop) exp_ovr++;
         else exp_q.push_back(e);
      end
      parity_en  = pen;
      parity_odd = podd;
      two_stop   = tstop;
      vt = -1;
      for (int k = 0; k < nb; k++) begin
         gpos = (glitch && k < fin) ? int'($urandom_range(1, OVS - 2)) : -1;
         for (int o = 0; o < OVS; o++) begin
            idx = k * OVS + o;
            if (idx == abort_at) return;
            if (k == 2 && o == 0) begin
               parity_en  = 1'($urandom);
               parity_odd = 1'($urandom);
               two_stop   = 1'($urandom);
            end
            v = (o == gpos) ? ~bits[k] : bits[k];
            do_tick(v);
            if (vt < 0 && rx_valid) vt = idx;
         end
      end
      if (chk_lat) check("latency_ticks", vt, fin * OVS + OVS / 2 + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DATA_BITS-1:0] rd;
      logic pen, podd, ts, pok, s1, s2;

      rst_n      = 1'b0;
      baud_tick  = 1'b0;
      rx_in      = 1'b1;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      two_stop   = 1'b0;
      rx_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle(4);

      // 8N1 0xA5
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // Even parity 0x03: wrong parity bit, then correct one
      run_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      run_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // Framing error followed by a held-low line, then a clean frame
      run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      for (int i = 0; i < 3 * OVS; i++) do_tick(1'b0);
      idle(4);
      run_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // Overrun: consumer stalled across two frames
      rx_ready = 1'b0;
      run_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      run_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
      idle(2);
      check("hold_valid", 32'(rx_valid), 32'd1);
      check("hold_data", 32'(rx_data), 32'h11);
      check("overrun_pulses", ovr_seen, exp_ovr);
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("drained_valid", 32'(rx_valid), 32'd0);
      check("drained_data_kept", 32'(rx_data), 32'h11);
      idle(2);

      // Short low glitch on an idle line is a false start
      do_tick(1'b0);
      check("glitch_busy_start", 32'(busy), 32'd1);
      for (int i = 1; i < 4; i++) do_tick(1'b0);
      for (int i = 4; i <= OVS / 2; i++) do_tick(1'b1);
      check("glitch_busy_before", 32'(busy), 32'd1);
      do_tick(1'b1);
      check("glitch_busy_after", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(rx_valid), 32'd0);
      idle(4);

      // Reset in the middle of a data bit aborts the frame
      run_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5 * OVS + 3);
      rst_n = 1'b0;
      rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      idle(4);
      run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // Random frames with noise inside and outside the sampling window
      for (int n = 0; n < 25; n++) begin
         rd   = DATA_BITS'($urandom);
         pen  = 1'($urandom);
         podd = 1'($urandom);
         ts   = 1'($urandom);
         pok  = ($urandom_range(0, 3) != 0);
         s1   = ($urandom_range(0, 7) != 0);
         s2   = ($urandom_range(0, 7) != 0);
         run_frame(rd, pen, podd, ts, pok, s1, s2, 1'b1, 1'b0, 1'b1, -1);
         idle(int'($urandom_range(2, 12)));
      end

      idle(4);
      check("unexpected_words", unexpected, 0);
      check("missing_words", exp_q.size(), 0);
      check("overrun_total", ovr_seen, exp_ovr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
